// File: rtl/spc_smp_io.sv
// spc_smp_io: SPC700 I/O register block at $00F0-$00FF.
//   Core side : CLK, RST (sync, active-high), CE (cycle enable), A, DI, WE_N
//               -> DO (combinational read data), SEL (address in $00Fx).
//   DSP side  : DSP_ADDR ($F2[6:0]), DSP_WE (one-CLK write pulse),
//               DSP_DI (registered $F3 write data), DSP_DO (read data).
//   IPL_EN    : $F1[7], IPL ROM overlay enable.
//   Main CPU  : CPU_ADDR/CPU_WR/CPU_DI write the in-latches,
//               CPU_DO returns out-latch[CPU_ADDR].
//   Timers    : 0/1 on the SLOW_DIV prescaler, 2 on the FAST_DIV prescaler.
module spc_smp_io #(
  parameter int unsigned SLOW_DIV = 128,
  parameter int unsigned FAST_DIV = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [15:0] A,
  input  logic [7:0]  DI,
  input  logic        WE_N,
  output logic [7:0]  DO,
  output logic        SEL,
  output logic [6:0]  DSP_ADDR,
  output logic        DSP_WE,
  output logic [7:0]  DSP_DI,
  input  logic [7:0]  DSP_DO,
  output logic        IPL_EN,
  input  logic [1:0]  CPU_ADDR,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DI,
  output logic [7:0]  CPU_DO
);

  localparam int unsigned SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int unsigned FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_DIV - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);

  logic [SW-1:0]      slow_q, slow_d;
  logic [FW-1:0]      fast_q, fast_d;
  logic               ipl_q, ipl_d;
  logic [2:0]         en_q, en_d;
  logic [7:0]         f2_q, f2_d;
  logic [7:0]         f8_q, f8_d;
  logic [7:0]         f9_q, f9_d;
  logic [3:0][7:0]    out_q, out_d;
  logic [3:0][7:0]    in_q, in_d;
  logic [2:0][7:0]    tgt_q, tgt_d;
  logic [2:0][7:0]    stage_q, stage_d;
  logic [2:0][3:0]    cnt_q, cnt_d;
  logic               dsp_we_q, dsp_we_d;
  logic [7:0]         dsp_di_q, dsp_di_d;

  logic               wr, rd;
  logic [3:0]         reg_a;
  logic               tick01, tick2;
  logic [2:0]         tick;
  logic [2:0]         inc;
  logic [2:0]         rd_clr;
  logic               unused_di;

  assign unused_di = ^{DI[6], DI[3]};

  assign SEL      = (A[15:4] == 12'h00F);
  assign reg_a    = A[3:0];
  assign wr       = CE & ~WE_N & SEL;
  assign rd       = CE & WE_N & SEL;

  assign DSP_ADDR = f2_q[6:0];
  assign DSP_WE   = dsp_we_q;
  assign DSP_DI   = dsp_di_q;
  assign IPL_EN   = ipl_q;
  assign CPU_DO   = out_q[CPU_ADDR];

  always_comb begin
    DO = '0;
    case (reg_a)
      4'h2:                      DO = f2_q;
      4'h3:                      DO = DSP_DO;
      4'h4, 4'h5, 4'h6, 4'h7:    DO = in_q[reg_a[1:0]];
      4'h8:                      DO = f8_q;
      4'h9:                      DO = f9_q;
      4'hD:                      DO = {4'b0, cnt_q[0]};
      4'hE:                      DO = {4'b0, cnt_q[1]};
      4'hF:                      DO = {4'b0, cnt_q[2]};
      default:                   DO = '0;
    endcase
  end

  always_comb begin
    tick01  = CE && (slow_q == SLOW_LAST);
    tick2   = CE && (fast_q == FAST_LAST);
    tick    = {tick2, tick01, tick01};
    rd_clr  = {rd && (reg_a == 4'hF), rd && (reg_a == 4'hE), rd && (reg_a == 4'hD)};

    slow_d   = slow_q;
    fast_d   = fast_q;
    ipl_d    = ipl_q;
    en_d     = en_q;
    f2_d     = f2_q;
    f8_d     = f8_q;
    f9_d     = f9_q;
    out_d    = out_q;
    in_d     = in_q;
    tgt_d    = tgt_q;
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    dsp_we_d = 1'b0;
    dsp_di_d = dsp_di_q;
    inc      = '0;

    if (CE) begin
      slow_d = tick01 ? '0 : slow_q + 1'b1;
      fast_d = tick2  ? '0 : fast_q + 1'b1;
    end

    // Target 0 falls out of the 8-bit compare as a 256-tick period.
    for (int unsigned n = 0; n < 3; n++) begin
      if (en_q[n] && tick[n]) begin
        if (stage_q[n] + 8'd1 == tgt_q[n]) begin
          stage_d[n] = '0;
          inc[n]     = 1'b1;
        end else begin
          stage_d[n] = stage_q[n] + 8'd1;
        end
      end
      // Read-clear first, then the increment, so a coincident tick leaves 1.
      cnt_d[n] = (rd_clr[n] ? 4'd0 : cnt_q[n]) + {3'b0, inc[n]};
    end

    if (wr) begin
      case (reg_a)
        4'h1: begin
          en_d  = DI[2:0];
          ipl_d = DI[7];
          for (int unsigned n = 0; n < 3; n++) begin
            if (DI[n] && !en_q[n]) begin
              stage_d[n] = '0;
              cnt_d[n]   = '0;
            end
          end
          if (DI[4]) begin
            in_d[0] = '0;
            in_d[1] = '0;
          end
          if (DI[5]) begin
            in_d[2] = '0;
            in_d[3] = '0;
          end
        end
        4'h2: f2_d = DI;
        4'h3: begin
          dsp_di_d = DI;
          dsp_we_d = ~f2_q[7];
        end
        4'h4, 4'h5, 4'h6, 4'h7: out_d[reg_a[1:0]] = DI;
        4'h8: f8_d = DI;
        4'h9: f9_d = DI;
        4'hA: tgt_d[0] = DI;
        4'hB: tgt_d[1] = DI;
        4'hC: tgt_d[2] = DI;
        default: ;
      endcase
    end

    // Main-CPU write is not gated by CE and overrides the $F1 clear strobes.
    if (CPU_WR) begin
      in_d[CPU_ADDR] = CPU_DI;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slow_q   <= '0;
      fast_q   <= '0;
      ipl_q    <= 1'b1;
      en_q     <= '0;
      f2_q     <= '0;
      f8_q     <= '0;
      f9_q     <= '0;
      out_q    <= '0;
      in_q     <= '0;
      tgt_q    <= '0;
      stage_q  <= '0;
      cnt_q    <= '0;
      dsp_we_q <= 1'b0;
      dsp_di_q <= '0;
    end else begin
      slow_q   <= slow_d;
      fast_q   <= fast_d;
      ipl_q    <= ipl_d;
      en_q     <= en_d;
      f2_q     <= f2_d;
      f8_q     <= f8_d;
      f9_q     <= f9_d;
      out_q    <= out_d;
      in_q     <= in_d;
      tgt_q    <= tgt_d;
      stage_q  <= stage_d;
      cnt_q    <= cnt_d;
      dsp_we_q <= dsp_we_d;
      dsp_di_q <= dsp_di_d;
    end
  end

endmodule

// File: tb/tb_spc_smp_io.sv
module tb_spc_smp_io;

  logic        CLK;
  logic        RST;
  logic        CE;
  logic [15:0] A;
  logic [7:0]  DI;
  logic        WE_N;
  logic [7:0]  DO;
  logic        SEL;
  logic [6:0]  DSP_ADDR;
  logic        DSP_WE;
  logic [7:0]  DSP_DI;
  logic [7:0]  DSP_DO;
  logic        IPL_EN;
  logic [1:0]  CPU_ADDR;
  logic        CPU_WR;
  logic [7:0]  CPU_DI;
  logic [7:0]  CPU_DO;

  spc_smp_io #(.SLOW_DIV(128), .FAST_DIV(16)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .A(A), .DI(DI), .WE_N(WE_N),
    .DO(DO), .SEL(SEL), .DSP_ADDR(DSP_ADDR), .DSP_WE(DSP_WE),
    .DSP_DI(DSP_DI), .DSP_DO(DSP_DO), .IPL_EN(IPL_EN),
    .CPU_ADDR(CPU_ADDR), .CPU_WR(CPU_WR), .CPU_DI(CPU_DI), .CPU_DO(CPU_DO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit         chk;
    logic [7:0] exp;
    string      name;
  } rd_exp_t;

  // Probe kinds: 0 IPL_EN, 1 CPU_DO, 2 DSP_ADDR, 3 DSP_DI, 4 DSP_WE pulse count
  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } pr_exp_t;

  rd_exp_t rd_q[$];
  pr_exp_t pr_q[$];
  logic    probe;
  int      errors;
  int      checks;
  int      ce_n;
  int      we_pulses;

  // Count of CE edges since reset; the fast prescaler ticks on every 16th.
  initial begin
    ce_n = 0;
    forever begin
      @(posedge CLK);
      if (RST) ce_n = 0;
      else if (CE) ce_n++;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a core read or a probe.
  initial begin
    rd_exp_t    r;
    pr_exp_t    p;
    logic [7:0] act;
    we_pulses = 0;
    forever begin
      @(negedge CLK);
      if (DSP_WE) we_pulses++;
      if (CE && WE_N && SEL) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_underflow: read of %04h with no expectation", A);
        end else begin
          r = rd_q.pop_front();
          if (r.chk) begin
            checks++;
            if (DO !== r.exp) begin
              errors++;
              $display("FAIL %s: DO=%02h expected %02h", r.name, DO, r.exp);
            end
          end
        end
      end
      if (probe) begin
        if (pr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL probe_underflow: probe with no expectation");
        end else begin
          p = pr_q.pop_front();
          case (p.kind)
            0:       act = {7'b0, IPL_EN};
            1:       act = CPU_DO;
            2:       act = {1'b0, DSP_ADDR};
            3:       act = DSP_DI;
            default: act = 8'(we_pulses);
          endcase
          checks++;
          if (act !== p.exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", p.name, act, p.exp);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    CE = 1'b1; WE_N = 1'b1; A = 16'h0000;
    repeat (n) @(posedge CLK);
    #1;
    CE = 1'b0;
  endtask

  task automatic core_wr(input logic [7:0] a, input logic [7:0] d);
    CE = 1'b1; WE_N = 1'b0; A = {8'h00, a}; DI = d;
    @(posedge CLK); #1;
    CE = 1'b0; WE_N = 1'b1; A = 16'h0000;
  endtask

  task automatic core_rd(input logic [7:0] a, input bit chk, input logic [7:0] e,
                         input string nm);
    rd_exp_t r;
    r.chk = chk; r.exp = e; r.name = nm;
    rd_q.push_back(r);
    CE = 1'b1; WE_N = 1'b1; A = {8'h00, a};
    @(posedge CLK); #1;
    CE = 1'b0; A = 16'h0000;
  endtask

  task automatic cpu_wr(input logic [1:0] p, input logic [7:0] d);
    CPU_ADDR = p; CPU_DI = d; CPU_WR = 1'b1;
    @(posedge CLK); #1;
    CPU_WR = 1'b0;
  endtask

  task automatic probe_out(input int kind, input logic [7:0] e, input string nm);
    pr_exp_t p;
    p.kind = kind; p.exp = e; p.name = nm;
    pr_q.push_back(p);
    probe = 1'b1;
    @(posedge CLK); #1;
    probe = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; probe = 1'b0;
    RST = 1'b1; CE = 1'b0; A = 16'h0000; DI = 8'h00; WE_N = 1'b1;
    DSP_DO = 8'h96; CPU_ADDR = 2'd0; CPU_WR = 1'b0; CPU_DI = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset state
    core_rd(8'hF1, 1, 8'h00, "rst_f1");
    core_rd(8'hFD, 1, 8'h00, "rst_fd");
    core_rd(8'hF4, 1, 8'h00, "rst_f4");
    probe_out(0, 8'h01, "rst_ipl_en");
    probe_out(1, 8'h00, "rst_cpu_do");

    // Plain registers and read-as-zero locations
    core_wr(8'hF0, 8'hFF);
    core_rd(8'hF0, 1, 8'h00, "f0_reads_zero");
    core_wr(8'hF8, 8'h5A);
    core_wr(8'hF9, 8'hC3);
    core_rd(8'hF8, 1, 8'h5A, "f8_rw");
    core_rd(8'hF9, 1, 8'hC3, "f9_rw");
    core_wr(8'hFC, 8'h07);
    core_rd(8'hFC, 1, 8'h00, "target_write_only");

    // Timer 0, target 3: 384 CE -> 3 ticks -> out counter 1
    core_wr(8'hFA, 8'h03);
    core_wr(8'hF1, 8'h01);
    idle(3 * 128);
    core_rd(8'hFD, 1, 8'h01, "t0_target3");
    core_rd(8'hFD, 1, 8'h00, "t0_read_clear");

    // Timer 0, target 0 (256 ticks)
    core_wr(8'hF1, 8'h00);
    core_wr(8'hFA, 8'h00);
    core_wr(8'hF1, 8'h01);
    idle(256 * 128);
    core_rd(8'hFD, 1, 8'h01, "t0_target0_256");

    // Timer 2, target 1: 20 ticks wrap the 4-bit counter to 4
    core_wr(8'hFC, 8'h01);
    core_wr(8'hF1, 8'h04);
    idle(20 * 16);
    core_rd(8'hFF, 1, 8'h04, "t2_wrap");
    core_wr(8'hF1, 8'h00);
    core_wr(8'hF1, 8'h04);
    core_rd(8'hFF, 1, 8'h00, "t2_reenable_clear");

    // Communication ports
    cpu_wr(2'd2, 8'hA5);
    cpu_wr(2'd0, 8'h11);
    core_rd(8'hF6, 1, 8'hA5, "cpu_to_core_p2");
    core_wr(8'hF5, 8'h3C);
    CPU_ADDR = 2'd1;
    probe_out(1, 8'h3C, "core_to_cpu_p1");
    core_wr(8'hF1, 8'h20);
    core_rd(8'hF6, 1, 8'h00, "f1_clear_p23");
    core_rd(8'hF4, 1, 8'h11, "f1_keep_p01");
    // Same-edge CPU write and $F1 clear of port 3
    CPU_ADDR = 2'd3; CPU_DI = 8'h77; CPU_WR = 1'b1;
    core_wr(8'hF1, 8'h20);
    CPU_WR = 1'b0;
    core_rd(8'hF7, 1, 8'h77, "cpu_wr_beats_clear");

    // DSP window
    core_wr(8'hF2, 8'h4C);
    core_wr(8'hF3, 8'h7F);
    idle(2);
    probe_out(2, 8'h4C, "dsp_addr");
    probe_out(3, 8'h7F, "dsp_di");
    probe_out(4, 8'h01, "dsp_we_one_pulse");
    core_wr(8'hF2, 8'hCC);
    core_wr(8'hF3, 8'h12);
    idle(2);
    probe_out(4, 8'h01, "dsp_we_blocked_f2_7");
    core_rd(8'hF2, 1, 8'hCC, "f2_rw");
    core_rd(8'hF3, 1, 8'h96, "f3_reads_dsp_do");

    // Read-clear coincident with an increment leaves 1
    core_wr(8'hF1, 8'h04);
    while (((ce_n + 1) % 16) != 0) idle(1);
    core_rd(8'hFF, 0, 8'h00, "t2_coincident_rd");
    core_rd(8'hFF, 1, 8'h01, "t2_clear_plus_inc");

    // IPL_EN follows $F1[7]
    core_wr(8'hF1, 8'h80);
    probe_out(0, 8'h01, "ipl_en_set");
    core_wr(8'hF1, 8'h00);
    probe_out(0, 8'h00, "ipl_en_clear");

    // Reset mid-operation
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    core_rd(8'hF2, 1, 8'h00, "rerst_f2");
    core_rd(8'hF8, 1, 8'h00, "rerst_f8");
    core_rd(8'hF7, 1, 8'h00, "rerst_f7");
    probe_out(0, 8'h01, "rerst_ipl_en");

    idle(2);
    if (rd_q.size() != 0 || pr_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d reads and %0d probes left unchecked", rd_q.size(), pr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spc_smp_io.md
Name: spc_smp_io

Overview:
- Memory-mapped responder for the SPC700 core's bus at $00F0-$00FF: control, DSP address/data window, main-CPU ports, scratch registers, three timers.
- Decodes the core's A_OUT/D_OUT/WE_N and returns read data for the top-level D_IN mux.
- Also serves the main-CPU side of the four communication ports.

Parameters:
- SLOW_DIV, 128, CE pulses per tick of timers 0/1 (8 kHz at 1.024 MHz).
- FAST_DIV, 16, CE pulses per tick of timer 2 (64 kHz).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- CE  in  1  SPC cycle enable; same signal as the core's EN. All state changes on the SPC side happen only when CE=1.
- A  in  16  core address.
- DI  in  8  core write data (D_OUT).
- WE_N  in  1  core write strobe, active low.
- DO  out  8  read data, combinational from A.
- SEL  out  1  A[15:4]==12'h00F, combinational.
- DSP_ADDR  out  7  $F2[6:0].
- DSP_WE  out  1  one-CLK pulse on a write to $F3 while $F2[7]=0.
- DSP_DI  out  8  registered $F3 write data.
- DSP_DO  in  8  DSP read data, returned on $F3 reads.
- IPL_EN  out  1  $F1[7], IPL ROM overlay enable.
- CPU_ADDR  in  2  main-CPU port select ($2140-$2143).
- CPU_WR  in  1  main-CPU write strobe, one CLK.
- CPU_DI  in  8  main-CPU write data.
- CPU_DO  out  8  out-latch[CPU_ADDR], combinational.

Behaviour:
- Access definitions:
  - Write: CE & ~WE_N & SEL.
  - Read: CE & WE_N & SEL. Side effects occur on that CLK edge.
- Reset values:
  - IPL_EN=1, all timers disabled, prescalers, stage counters and out counters 0, targets 0.
  - Out/in port latches 0, $F2=0, $F8=$F9=0, DSP_WE=0, DSP_DI=0.
- $F0: write ignored, read 0.
- $F1 write:
  - Bits[2:0] = timer enables.
  - A 0->1 transition of enable n clears stage n and out counter n on that edge. 1->1 clears nothing.
  - Bit4=1 clears in-latches 0/1. Bit5=1 clears in-latches 2/3. Both bits are strobes, not stored.
  - Bit7 sets IPL_EN.
  - Read of $F1 returns 0.
- $F2: read/write 8-bit. $F3 read returns DSP_DO.
- $F4-$F7:
  - Read returns in-latch[A[1:0]].
  - Write sets out-latch[A[1:0]].
- $F8/$F9: plain 8-bit read/write.
- $FA-$FC: timer targets 0-2, write-only, read 0. Target 0 means 256.
- Prescalers:
  - The slow prescaler counts CE pulses 0..SLOW_DIV-1 and pulses tick01 on wrap.
  - The fast prescaler is the same with FAST_DIV and pulses tick2.
  - Both run freely regardless of enables.
- Timer n, when enabled, on each tick:
  - 8-bit stage increments.
  - When stage+1 == target (mod 256), stage becomes 0 and 4-bit out counter increments, wrapping 15->0.
- $FD-$FF:
  - Read returns {4'b0, out counter} and clears the counter.
  - Read-clear and increment on the same edge give counter=1.
  - Writes are ignored.
- Main CPU:
  - CPU_WR writes in-latch[CPU_ADDR] regardless of CE.
  - Same-edge CPU_WR and $F1 clear of that latch: the CPU write wins.
- Timing:
  - DO/SEL have zero latency; the core samples them at the end of the access cycle.
  - DSP_WE asserts the CLK after the write edge, for one CLK.
- Enables, targets and latches retain value across timer ticks. RST mid-operation returns everything to reset values on the next edge.

Test Plan:
- Reset then read $F1, $FD, $F4 -> 0. IPL_EN=1. CPU_DO=0.
- Write $FA=3, $F1=01, run 3*128 CE -> $FD reads 1, immediate re-read 0. Target 0 (256 ticks) yields 1 after 256*128 CE.
- Timer 2 target 1, enabled, run 20*16 CE without reading -> $FF reads 4 (20 mod 16). Re-enable via $F1=00 then 04 -> reads 0.
- CPU_WR port 2 with 8'hA5 -> core read $F6=A5. Core write $F5=3C -> CPU_ADDR=1 gives CPU_DO=3C. $F1=20 -> $F6 reads 0.
- Write $F2=0x4C, $F3=0x7F -> DSP_ADDR=4C, DSP_WE one pulse, DSP_DI=7F. With $F2=0xCC the same write gives no DSP_WE.
- Read of $FD coincident with increment -> counter=1. $F1=00 -> IPL_EN=0.
